// File: rtl/addsub_unit_if.sv
// Issue and CDB signal bundle for addsub_unit; cdb_ovf exists only when ADDSUB_OVF_EN is defined.
interface addsub_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             cdb_req;
    logic             cdb_grant;
    logic [WIDTH-1:0] cdb_data;
    logic [TAG_W-1:0] cdb_tag;
    logic             busy;
`ifdef ADDSUB_OVF_EN
    logic             cdb_ovf;
`endif

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, cdb_grant,
`ifdef ADDSUB_OVF_EN
        input  cdb_ovf,
`endif
        input  in_ready, cdb_req, cdb_data, cdb_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, cdb_grant,
`ifdef ADDSUB_OVF_EN
        output cdb_ovf,
`endif
        output in_ready, cdb_req, cdb_data, cdb_tag, busy
    );
endinterface

// File: rtl/addsub_unit.sv
// Add/subtract execution unit: one execute stage feeding a DEPTH-entry FIFO toward the CDB.
// Optional macro ADDSUB_OVF_EN adds a per-entry signed-overflow flag on cdb_ovf.
module addsub_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         RST,
    addsub_unit_if.slave io
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    logic             r_ex_valid;
    logic             r_ex_op;
    logic [WIDTH-1:0] r_ex_a;
    logic [WIDTH-1:0] r_ex_b;
    logic [TAG_W-1:0] r_ex_tag;

    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [DEPTH];
`ifdef ADDSUB_OVF_EN
    logic             r_mem_ovf  [DEPTH];
    logic             w_ovf;
`endif
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_result;
    logic [CNT_W:0]   w_total;
    logic             w_req;
    logic             w_pop;
    logic             w_push;
    logic             w_accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Subtract is a + ~b + 1, so the carry-in is simply the op bit.
    always_comb begin
        w_b_eff  = r_ex_op ? ~r_ex_b : r_ex_b;
        w_result = r_ex_a + w_b_eff + {{(WIDTH-1){1'b0}}, r_ex_op};
    end

`ifdef ADDSUB_OVF_EN
    always_comb begin
        w_ovf = (r_ex_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                (w_result[WIDTH-1] != r_ex_a[WIDTH-1]);
    end
`endif

    // Occupancy never exceeds DEPTH, so the execute register can always drain into the buffer.
    always_comb begin
        w_req    = (r_count != '0);
        w_pop    = w_req && io.cdb_grant;
        w_push   = r_ex_valid;
        w_total  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_ex_valid};
        io.in_ready = (w_total < DEPTH_SUM) || ((w_total == DEPTH_SUM) && w_pop);
        w_accept = io.in_valid && io.in_ready;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_ex_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload registers need no reset; they are only observed behind valid/count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ex_op  <= io.in_op;
            r_ex_a   <= io.in_a;
            r_ex_b   <= io.in_b;
            r_ex_tag <= io.in_tag;
        end
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_result;
            r_mem_tag[r_wr_ptr]  <= r_ex_tag;
`ifdef ADDSUB_OVF_EN
            r_mem_ovf[r_wr_ptr]  <= w_ovf;
`endif
        end
    end

    always_comb begin
        io.cdb_req  = w_req;
        io.cdb_data = w_req ? r_mem_data[r_rd_ptr] : '0;
        io.cdb_tag  = w_req ? r_mem_tag[r_rd_ptr]  : '0;
        io.busy     = r_ex_valid || w_req;
`ifdef ADDSUB_OVF_EN
        io.cdb_ovf  = w_req ? r_mem_ovf[r_rd_ptr] : 1'b0;
`endif
    end
endmodule

// File: tb/tb_addsub_unit.sv
// Self-checking bench for addsub_unit: queue-based reference model plus directed literal cases.
module tb_addsub_unit;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int DEPTH = 2;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    addsub_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) io ();

    addsub_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .RST(RST),
        .io (io)
    );

    int   tests = 0;
    int   fails = 0;
    bit   live  = 1'b0;
    res_t pend[$];
    res_t bufq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t compute(input bit op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] tag);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] sv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = op ? (sa - sb) : (sa + sb);
        sv = s;
        r.data = sv[31:0];
        r.tag  = tag;
        r.ovf  = (s > SMAX) || (s < SMIN);
        return r;
    endfunction

    function automatic bit exp_ready();
        int total;
        total = pend.size() + bufq.size();
        return (total < DEPTH) || ((total == DEPTH) && (bufq.size() > 0) && (io.cdb_grant == 1'b1));
    endfunction

    // Model advances on each rising edge using the inputs presented in that cycle.
    always @(posedge clk) begin
        if (RST) begin
            pend.delete();
            bufq.delete();
            live = 1'b1;
        end else if (live) begin
            bit rdy;
            rdy = exp_ready();
            if (bufq.size() > 0 && io.cdb_grant) void'(bufq.pop_front());
            if (pend.size() > 0) bufq.push_back(pend.pop_front());
            if (io.in_valid && rdy) pend.push_back(compute(io.in_op, io.in_a, io.in_b, io.in_tag));
        end
    end

    always @(negedge clk) begin
        if (live) begin
            res_t h;
            h = '0;
            if (bufq.size() > 0) h = bufq[0];
            chk("m_req",   io.cdb_req,  bufq.size() > 0);
            chk("m_data",  io.cdb_data, h.data);
            chk("m_tag",   io.cdb_tag,  h.tag);
            chk("m_busy",  io.busy,     (pend.size() + bufq.size()) > 0);
            chk("m_ready", io.in_ready, exp_ready());
`ifdef ADDSUB_OVF_EN
            chk("m_ovf",   io.cdb_ovf,  h.ovf);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        io.in_valid = v;
        io.in_op    = op;
        io.in_a     = a;
        io.in_b     = b;
        io.in_tag   = tag;
    endtask

    task automatic single(input string name, input bit op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp_data, input bit exp_ovf);
        io.cdb_grant = 1'b0;
        drive(1'b1, op, a, b, tag);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        tick();
        @(negedge clk);
        chk({name, "_req"},  io.cdb_req,  1'b1);
        chk({name, "_data"}, io.cdb_data, exp_data);
        chk({name, "_tag"},  io.cdb_tag,  tag);
`ifdef ADDSUB_OVF_EN
        chk({name, "_ovf"},  io.cdb_ovf,  exp_ovf);
`else
        if (exp_ovf) begin end
`endif
        tick();
        io.cdb_grant = 1'b1;
        tick();
        io.cdb_grant = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        io.cdb_grant = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        RST = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_req",   io.cdb_req,  1'b0);
        chk("rst_data",  io.cdb_data, 32'h0);
        chk("rst_tag",   io.cdb_tag,  4'h0);
        chk("rst_busy",  io.busy,     1'b0);
        chk("rst_ready", io.in_ready, 1'b1);
        tick();
        RST = 1'b0;

        // Add 5+7 tag 3, held without grant
        drive(1'b1, 1'b0, 32'd5, 32'd7, 4'd3);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("lat_req_n1",  io.cdb_req, 1'b0);
        chk("lat_busy_n1", io.busy,    1'b1);
        tick();
        @(negedge clk);
        chk("lat_req_n2", io.cdb_req,  1'b1);
        chk("add_data",   io.cdb_data, 32'd12);
        chk("add_tag",    io.cdb_tag,  4'd3);
        tick();
        tick();
        @(negedge clk);
        chk("hold_data", io.cdb_data, 32'd12);
        tick();
        io.cdb_grant = 1'b1;
        tick();
        io.cdb_grant = 1'b0;
        @(negedge clk);
        chk("pop_req",  io.cdb_req, 1'b0);
        chk("pop_busy", io.busy,    1'b0);
        tick();

        single("sub_neg",  1'b1, 32'd3,          32'd5, 4'd1, 32'hFFFF_FFFE, 1'b0);
        single("add_wrap", 1'b0, 32'hFFFF_FFFF,  32'd1, 4'd2, 32'h0000_0000, 1'b0);
        single("ovf_add",  1'b0, 32'h7FFF_FFFF,  32'd1, 4'd4, 32'h8000_0000, 1'b1);
        single("ovf_sub",  1'b1, 32'h8000_0000,  32'd1, 4'd5, 32'h7FFF_FFFF, 1'b1);
        single("no_ovf",   1'b0, 32'd1,          32'd1, 4'd6, 32'd2,         1'b0);

        // Three ops into a DEPTH=2 unit with grant low: the third stalls
        io.cdb_grant = 1'b0;
        drive(1'b1, 1'b0, 32'd10, 32'd20, 4'd1);
        tick();
        drive(1'b1, 1'b1, 32'd100, 32'd1, 4'd2);
        tick();
        drive(1'b1, 1'b0, 32'd1, 32'd2, 4'd5);
        @(negedge clk);
        chk("stall_ready_a", io.in_ready, 1'b0);
        chk("stall_head_a",  io.cdb_data, 32'd30);
        tick();
        @(negedge clk);
        chk("stall_ready_b", io.in_ready, 1'b0);
        chk("stall_head_b",  io.cdb_data, 32'd30);
        tick();
        io.cdb_grant = 1'b1;
        @(negedge clk);
        chk("grant_frees",   io.in_ready, 1'b1);
        chk("grant_head",    io.cdb_tag,  4'd1);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("order_2_data", io.cdb_data, 32'd99);
        chk("order_2_tag",  io.cdb_tag,  4'd2);
        tick();
        @(negedge clk);
        chk("order_3_data", io.cdb_data, 32'd3);
        chk("order_3_tag",  io.cdb_tag,  4'd5);
        tick();
        io.cdb_grant = 1'b0;
        @(negedge clk);
        chk("drain_req",  io.cdb_req, 1'b0);
        chk("drain_busy", io.busy,    1'b0);
        tick();

        // Back-to-back issue with grant held: one result per cycle, no bubbles
        io.cdb_grant = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(k < 8, 1'b0, 32'(k), 32'd100, 4'(k));
            @(negedge clk);
            if (k < 8) chk("b2b_ready", io.in_ready, 1'b1);
            if (k >= 2) begin
                chk("b2b_req",  io.cdb_req,  1'b1);
                chk("b2b_tag",  io.cdb_tag,  4'(k - 2));
                chk("b2b_data", io.cdb_data, 32'(k - 2 + 100));
            end
            tick();
        end
        io.cdb_grant = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("b2b_empty", io.cdb_req, 1'b0);
        tick();

        // Reset with two buffered results while handshakes are active
        drive(1'b1, 1'b0, 32'd1, 32'd1, 4'd7);
        tick();
        drive(1'b1, 1'b0, 32'd2, 32'd2, 4'd8);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        tick();
        @(negedge clk);
        chk("pre_rst_busy", io.busy,    1'b1);
        chk("pre_rst_req",  io.cdb_req, 1'b1);
        tick();
        RST = 1'b1;
        io.cdb_grant = 1'b1;
        drive(1'b1, 1'b0, 32'd9, 32'd9, 4'd9);
        tick();
        RST = 1'b0;
        io.cdb_grant = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("post_rst_req",   io.cdb_req,  1'b0);
        chk("post_rst_busy",  io.busy,     1'b0);
        chk("post_rst_ready", io.in_ready, 1'b1);
        chk("post_rst_data",  io.cdb_data, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("no_stale", io.cdb_req, 1'b0);
        end
        tick();

        // Randomised traffic with occasional resets; the model checks every cycle
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_operand(),
                  pick_operand(), 4'($urandom_range(0, 15)));
            io.cdb_grant = ($urandom_range(0, 2) != 0);
            tick();
        end
        RST = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        io.cdb_grant = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        @(negedge clk);
        chk("final_idle", io.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/addsub_unit.md
ADDSUB_UNIT -- requirements
Module: addsub_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-002 Parameter TAG_W, default 4, SHALL set the width of the reservation-station tag carried with each operation.
REQ-003 Parameter DEPTH, default 2, SHALL set the result-buffer capacity in entries (DEPTH >= 1).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  issue request from the reservation station.
REQ-007 in_ready  output  1  unit can accept an operation this cycle.
REQ-008 in_op  input  1  0 = add, 1 = subtract.
REQ-009 in_a, in_b  input  WIDTH each  operands.
REQ-010 in_tag  input  TAG_W  destination tag.
REQ-011 cdb_req  output  1  buffered result waiting for the CDB.
REQ-012 cdb_grant  input  1  CDB arbiter accepts the head result this cycle.
REQ-013 cdb_data  output  WIDTH; cdb_tag  output  TAG_W  head result and tag.
REQ-014 busy  output  1  operation in flight or buffered.

Function
REQ-015 Issue handshake: an operation SHALL be accepted on an edge where in_valid && in_ready; inputs SHALL be ignored otherwise.
REQ-016 Pipeline: an operation accepted at edge N SHALL be in the execute register during cycle N+1 and written to the result buffer at edge N+1.
REQ-017 cdb_req SHALL be high during the cycle after that write (earliest: cycle N+2 of issue) and whenever the buffer is non-empty.
REQ-018 Add: result = (in_a + in_b) mod 2^WIDTH; subtract: result = (in_a + ~in_b + 1) mod 2^WIDTH (full two's complement, carry-in 1).
REQ-019 Carry-out SHALL be discarded; wrap-around is silent.
REQ-020 Buffer SHALL be FIFO ordered; cdb_data/cdb_tag SHALL present the oldest entry.
REQ-021 Pop: head entry SHALL be removed on an edge where cdb_req && cdb_grant; cdb_grant while cdb_req low SHALL be ignored.
REQ-022 cdb_data and cdb_tag SHALL be zero when cdb_req is low.
REQ-023 in_ready SHALL be high iff (execute-register occupancy + buffer count) < DEPTH, or that sum equals DEPTH and cdb_req && cdb_grant this cycle (same-cycle pop frees a slot).
REQ-024 Simultaneous push into and pop from the buffer on one edge SHALL leave the count unchanged and preserve order.
REQ-025 Buffer pointers SHALL wrap modulo DEPTH; no entry SHALL be overwritten or lost.
REQ-026 Back-to-back issue SHALL sustain one operation per cycle while cdb_grant is held high.
REQ-027 busy SHALL be high iff the execute register is occupied or the buffer is non-empty.

Reset
REQ-028 RST high at an edge SHALL clear the execute register, buffer pointers and count, discarding all in-flight and buffered results, regardless of handshakes in that cycle.
REQ-029 During and after reset, until the next accepted issue: cdb_req = 0, cdb_data = 0, cdb_tag = 0, busy = 0, in_ready = 1.

Configuration
REQ-030 Macro ADDSUB_OVF_EN defined: the unit SHALL add output cdb_ovf (1 bit), the signed overflow of the head result (operand signs equal after subtract-inversion and result sign differs), stored per entry, zero when cdb_req low or after reset.
REQ-031 Macro ADDSUB_OVF_EN undefined: port cdb_ovf and its per-entry storage SHALL NOT exist; all other behaviour identical.

Verification
REQ-032 Reset, then issue add a=5, b=7, tag=3 with cdb_grant=0 -> cdb_req high two cycles after issue, cdb_data=12, cdb_tag=3, held until grant.
REQ-033 WIDTH=32: subtract a=3, b=5 -> cdb_data=0xFFFFFFFE; add 0xFFFFFFFF+1 -> cdb_data=0 (wrap).
REQ-034 DEPTH=2, cdb_grant=0: issue three ops -> third stalls with in_ready=0; raise cdb_grant -> results popped in issue order, third accepted in the grant cycle.
REQ-035 cdb_grant held high, in_valid high for 8 cycles with tags 0..7 -> one result per cycle, tags 0..7 in order, no bubbles after initial latency.
REQ-036 Two results buffered, assert RST for one cycle -> next cycle cdb_req=0, busy=0, in_ready=1; no stale result ever appears.
REQ-037 ADDSUB_OVF_EN defined: add 0x7FFFFFFF+1 -> cdb_ovf=1; subtract 0x80000000-1 -> cdb_ovf=1; add 1+1 -> cdb_ovf=0.
